// File: rtl/sa_cell_pipe.sv
// FP16 systolic-array cell: weight FIFO with cyclic reuse, two-stage valid/ready
// pipeline (multiply, then output/accumulate) and a forwarded copy of the input stream.

// Combinational FP16 multiplier: round-to-nearest-even, subnormals flushed to zero, canonical NaN 0x7E00.
module mult_IEEE754_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_p
);
  logic              w_sign;
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [21:0]       w_prod;
  logic signed [7:0] w_exp;
  logic [9:0]        w_mant;
  logic              w_g, w_st;
  logic [10:0]       w_rnd;

  always_comb begin
    w_sign   = i_a[15] ^ i_b[15];
    w_a_zero = (i_a[14:10] == 5'd0);
    w_b_zero = (i_b[14:10] == 5'd0);
    w_a_inf  = (i_a[14:10] == 5'h1f) && (i_a[9:0] == 10'd0);
    w_b_inf  = (i_b[14:10] == 5'h1f) && (i_b[9:0] == 10'd0);
    w_a_nan  = (i_a[14:10] == 5'h1f) && (i_a[9:0] != 10'd0);
    w_b_nan  = (i_b[14:10] == 5'h1f) && (i_b[9:0] != 10'd0);
    w_prod   = 22'({1'b1, i_a[9:0]}) * 22'({1'b1, i_b[9:0]});
    w_exp    = $signed({3'b000, i_a[14:10]}) + $signed({3'b000, i_b[14:10]}) - 8'sd15;
    w_mant   = w_prod[19:10];
    w_g      = w_prod[9];
    w_st     = |w_prod[8:0];
    if (w_prod[21]) begin
      w_mant = w_prod[20:11];
      w_g    = w_prod[10];
      w_st   = |w_prod[9:0];
      w_exp  = w_exp + 8'sd1;
    end
    w_rnd = {1'b0, w_mant} + {10'd0, w_g & (w_st | w_mant[0])};
    // Rounding carry out of the mantissa leaves w_rnd[9:0] == 0 and bumps the exponent.
    if (w_rnd[10]) w_exp = w_exp + 8'sd1;

    if (w_a_nan || w_b_nan)          o_p = 16'h7e00;
    else if (w_a_inf || w_b_inf)     o_p = (w_a_zero || w_b_zero) ? 16'h7e00 : {w_sign, 5'h1f, 10'd0};
    else if (w_a_zero || w_b_zero)   o_p = {w_sign, 15'd0};
    else if (w_exp >= 8'sd31)        o_p = {w_sign, 5'h1f, 10'd0};
    else if (w_exp <= 8'sd0)         o_p = {w_sign, 15'd0};
    else                             o_p = {w_sign, w_exp[4:0], w_rnd[9:0]};
  end
endmodule

// Combinational FP16 adder: same rounding/flush rules as the multiplier; exact cancellation gives +0.
module adder_IEEE754_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);
  logic              w_a_big;
  logic [15:0]       w_l, w_s;
  logic [4:0]        w_d;
  logic [13:0]       w_ml, w_ms, w_ms_sh, w_mask, w_n;
  logic [14:0]       w_sum;
  logic              w_sub, w_g, w_st;
  logic [3:0]        w_lz;
  logic signed [6:0] w_e;
  logic [10:0]       w_rnd;
  logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  function automatic logic [3:0] f_lzc(input logic [13:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 14; i++)
      if (v[i]) n = 4'(13 - i);
    return n;
  endfunction

  always_comb begin
    w_a_zero = (i_a[14:10] == 5'd0);
    w_b_zero = (i_b[14:10] == 5'd0);
    w_a_inf  = (i_a[14:10] == 5'h1f) && (i_a[9:0] == 10'd0);
    w_b_inf  = (i_b[14:10] == 5'h1f) && (i_b[9:0] == 10'd0);
    w_a_nan  = (i_a[14:10] == 5'h1f) && (i_a[9:0] != 10'd0);
    w_b_nan  = (i_b[14:10] == 5'h1f) && (i_b[9:0] != 10'd0);
    w_a_big  = (i_a[14:0] >= i_b[14:0]);
    w_l      = w_a_big ? i_a : i_b;
    w_s      = w_a_big ? i_b : i_a;
    w_sub    = w_l[15] ^ w_s[15];
    w_d      = w_l[14:10] - w_s[14:10];
    w_ml     = {1'b1, w_l[9:0], 3'b000};
    w_ms     = {1'b1, w_s[9:0], 3'b000};
    w_mask   = (14'd1 << w_d) - 14'd1;
    // Bits shifted out of the smaller operand collapse into a sticky LSB.
    if (w_d >= 5'd14) w_ms_sh = 14'd1;
    else              w_ms_sh = (w_ms >> w_d) | {13'd0, |(w_ms & w_mask)};
    w_sum = w_sub ? ({1'b0, w_ml} - {1'b0, w_ms_sh}) : ({1'b0, w_ml} + {1'b0, w_ms_sh});
    w_e   = $signed({2'b00, w_l[14:10]});
    w_lz  = f_lzc(w_sum[13:0]);
    if (w_sum[14]) begin
      w_n = w_sum[14:1] | {13'd0, w_sum[0]};
      w_e = w_e + 7'sd1;
    end else begin
      w_n = w_sum[13:0] << w_lz;
      w_e = w_e - $signed({3'b000, w_lz});
    end
    w_g   = w_n[2];
    w_st  = w_n[1] | w_n[0];
    w_rnd = {1'b0, w_n[12:3]} + {10'd0, w_g & (w_st | w_n[3])};
    if (w_rnd[10]) w_e = w_e + 7'sd1;

    if (w_a_nan || w_b_nan)        o_sum = 16'h7e00;
    else if (w_a_inf && w_b_inf)   o_sum = (i_a[15] != i_b[15]) ? 16'h7e00 : i_a;
    else if (w_a_inf)              o_sum = i_a;
    else if (w_b_inf)              o_sum = i_b;
    else if (w_a_zero)             o_sum = w_b_zero ? {i_a[15] & i_b[15], 15'd0} : i_b;
    else if (w_b_zero)             o_sum = i_a;
    else if (w_sum == 15'd0)       o_sum = 16'h0000;
    else if (w_e >= 7'sd31)        o_sum = {w_l[15], 5'h1f, 10'd0};
    else if (w_e <= 7'sd0)         o_sum = {w_l[15], 15'd0};
    else                           o_sum = {w_l[15], w_e[4:0], w_rnd[9:0]};
  end
endmodule

module sa_cell_pipe #(
  parameter int DATA_WIDTH      = 16,
  parameter int WD_BUFFER_DEPTH = 16,
  parameter int ACC_LEN_WIDTH   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [1:0]                         mode,
  input  logic [ACC_LEN_WIDTH-1:0]           acc_len,
  input  logic                               add_sub,
  input  logic                               clear_weights,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic                               data_in_valid,
  output logic                               data_in_ready,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               data_out_valid,
  input  logic                               data_out_ready,
  output logic [DATA_WIDTH-1:0]              right_out,
  output logic                               right_out_valid,
  output logic [$clog2(WD_BUFFER_DEPTH):0]   wd_count,
  output logic                               busy,
  output logic                               err
);
  localparam int PW = $clog2(WD_BUFFER_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_LOAD = 2'd1;
  localparam logic [1:0] MODE_ELEM = 2'd2;
  localparam logic [1:0] MODE_ACC  = 2'd3;

  // Handshake: a word moves across an interface on a cycle where its valid and ready are both high;
  // data_out is held while data_out_valid & !data_out_ready, which also freezes both pipeline stages.
  logic [DATA_WIDTH-1:0]    r_wd_buf [WD_BUFFER_DEPTH];
  logic [PW-1:0]            r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]            r_wd_count;
  logic [DATA_WIDTH-1:0]    r_p_reg, r_data_out, r_right_out, r_acc;
  logic                     r_p_valid, r_dov, r_rov, r_err;
  logic [ACC_LEN_WIDTH-1:0] r_acc_cnt;
  logic [1:0]               r_mode_q;

  logic                     w_advance, w_compute, w_ready, w_accept, w_load_wr;
  logic                     w_rd_wrap, w_discard;
  logic [ACC_LEN_WIDTH-1:0] w_acc_last;
  logic [DATA_WIDTH-1:0]    w_weight, w_product, w_addend, w_sum;

  assign w_advance  = !r_dov || data_out_ready;
  assign w_compute  = (mode == MODE_ELEM) || (mode == MODE_ACC);
  always_comb begin
    w_ready = 1'b0;
    if (mode == MODE_LOAD) w_ready = (r_wd_count < CW'(WD_BUFFER_DEPTH));
    else if (w_compute)    w_ready = w_advance && (r_wd_count != '0);
  end
  assign w_accept   = data_in_valid && w_ready && rst;
  assign w_load_wr  = w_accept && (mode == MODE_LOAD) && !clear_weights;
  assign w_rd_wrap  = ({1'b0, r_rd_ptr} == (r_wd_count - 1'b1));
  assign w_acc_last = (acc_len == '0) ? '0 : acc_len - 1'b1;
  assign w_discard  = (mode != r_mode_q) && (r_acc_cnt != '0);
  assign w_weight   = r_wd_buf[r_rd_ptr];
  assign w_addend   = add_sub ? {~r_p_reg[DATA_WIDTH-1], r_p_reg[DATA_WIDTH-2:0]} : r_p_reg;

  mult_IEEE754_16bit u_mult (.i_a(data_in), .i_b(w_weight), .o_p(w_product));
  adder_IEEE754_16bit u_add (.i_a(r_acc), .i_b(w_addend), .o_sum(w_sum));

  always_ff @(posedge clk) begin
    if (w_load_wr) r_wd_buf[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_wd_count  <= '0;
      r_p_reg     <= '0;
      r_p_valid   <= 1'b0;
      r_data_out  <= '0;
      r_dov       <= 1'b0;
      r_right_out <= '0;
      r_rov       <= 1'b0;
      r_acc       <= '0;
      r_acc_cnt   <= '0;
      r_err       <= 1'b0;
      r_mode_q    <= MODE_IDLE;
    end else begin
      r_mode_q <= mode;
      r_rov    <= w_accept;
      if (w_accept) r_right_out <= data_in;

      if (clear_weights) begin
        r_wd_count <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_load_wr) begin
          r_wr_ptr   <= r_wr_ptr + 1'b1;
          r_wd_count <= r_wd_count + 1'b1;
        end
        if (w_accept && w_compute) r_rd_ptr <= w_rd_wrap ? '0 : r_rd_ptr + 1'b1;
      end

      if (w_advance) begin
        r_p_valid <= w_accept && w_compute;
        if (w_accept && w_compute) r_p_reg <= w_product;
        if (r_p_valid) begin
          // Products draining under IDLE/LOAD are emitted as plain elementwise results.
          if (mode == MODE_ACC) begin
            if (r_acc_cnt >= w_acc_last) begin
              r_data_out <= w_sum;
              r_dov      <= 1'b1;
              r_acc      <= '0;
              r_acc_cnt  <= '0;
            end else begin
              r_acc     <= w_sum;
              r_acc_cnt <= r_acc_cnt + 1'b1;
              r_dov     <= 1'b0;
            end
          end else begin
            r_data_out <= r_p_reg;
            r_dov      <= 1'b1;
          end
        end else begin
          r_dov <= 1'b0;
        end
      end

      if (w_discard) begin
        r_acc     <= '0;
        r_acc_cnt <= '0;
        r_err     <= 1'b1;
      end
    end
  end

  assign data_in_ready   = w_ready && rst;
  assign data_out        = r_data_out;
  assign data_out_valid  = r_dov;
  assign right_out       = r_right_out;
  assign right_out_valid = r_rov;
  assign wd_count        = r_wd_count;
  assign busy            = r_p_valid || r_dov || (r_acc_cnt != '0);
  assign err             = r_err;
endmodule
